phy_tx_serializer: RTL and testbench
====================================

Name: phy_tx_serializer

Overview:
- Two-lane byte-to-serial transmitter; the transmit end of the lane protocol decoded by phy_rx.
- Per lane: accepts one byte every 8 clocks from the upstream byte/valid source and drives one bit per clk_8f cycle, MSB first.
- After enable, sends SYNC_BYTES comma bytes on both lanes so the receiver can lock.
- Then sends data bytes; in any slot where a lane's valid is low, that lane sends IDLE_BYTE.

Parameters:
- SYNC_BYTES, 4, number of comma bytes sent on both lanes after enable rises, before any data slot (legal range 1..15).
- IDLE_BYTE, 8'hBC, comma byte sent during sync and for idle slots.

Ports:
- clk_8f  input  1  bit clock; sole clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  transmit enable.
- data_in_0  input  8  lane 0 byte.
- valid_in_0  input  1  lane 0 byte valid.
- data_in_1  input  8  lane 1 byte.
- valid_in_1  input  1  lane 1 byte valid.
- ready  output  1  high for one cycle: data_in_x/valid_in_x are sampled at the next rising edge.
- out_0  output  1  lane 0 serial bit.
- out_1  output  1  lane 1 serial bit.
- active  output  1  high while in ACTIVE state.

Behaviour:
- Clocking and reset: single clock clk_8f; reset is asynchronous and active-high.
- Reset values: out_0=0, out_1=0, ready=0, active=0, state=OFF, bit_cnt=0, sync_cnt=0, shift registers=0.
- Internal state:
  - bit_cnt: 3 bits.
  - sync_cnt: 4 bits.
  - shreg_0, shreg_1: 8 bits each.
  - out_x = shreg_x[7], taken directly from the flop with no combinational path to the output.
- OFF state:
  - Outputs held 0.
  - Edge with enable=1: load IDLE_BYTE into both shift registers; bit_cnt=0, sync_cnt=0; go to SYNC.
  - Bit 7 of the comma appears one cycle after enable is sampled high.
- SYNC and ACTIVE, every edge:
  - If bit_cnt!=7: shift both registers left by 1 (shifting in 0), bit_cnt+1.
  - If bit_cnt==7: bit_cnt=0 and a new byte is loaded (byte boundary). Each byte occupies exactly 8 cycles, with no gaps between bytes.
- SYNC at a byte boundary:
  - If sync_cnt < SYNC_BYTES-1: load IDLE_BYTE, sync_cnt+1.
  - Else: go to ACTIVE and load a data slot (the first data slot follows immediately).
- Data slot load, per lane independently: shreg_x = valid_in_x ? data_in_x : IDLE_BYTE.
- ready (combinational from registered state) = (bit_cnt==7) && (state==ACTIVE || (state==SYNC && sync_cnt==SYNC_BYTES-1)).
  - Upstream must present data/valid while ready is high.
  - Data held at other times is ignored; nothing is buffered.
- active = registered (state==ACTIVE).
- enable low at any edge in SYNC or ACTIVE:
  - Go to OFF immediately, even mid-byte; the partial byte is dropped.
  - Next cycle: out_x=0, ready=0, active=0.
  - Re-enable restarts the full sync sequence.
- reset asserted mid-byte: same abort effect as enable low, applied asynchronously.
- Both lanes are always bit-aligned; they share bit_cnt and state.

Optional Feature:
- Macro: PHY_TX_BYTE_COUNT_EN.
- Defined:
  - Adds outputs tx_count_0 and tx_count_1, 16 bits each.
  - tx_count_x increments at every data-slot load with valid_in_x=1.
  - Counters wrap 16'hFFFF -> 0.
  - Cleared by reset and on the OFF->SYNC transition.
  - Idle slots do not count.
- Undefined: the ports do not exist; there is no counter logic.

Test Plan:
- Sync sequence: reset 1->0, enable=1 -> from the next cycle, out_0 and out_1 both 10111100 repeated 4 times (32 cycles); ready first high in cycle 32; active=1 from cycle 33.
- Data: valid_in_0=1, data_in_0=8'hFF, valid_in_1=1, data_in_1=8'h00 at the first ready -> out_0=11111111, out_1=00000000; then 8'hEE/8'hDD -> 11101110 / 11011101; ready pulses every 8 cycles.
- Mixed valid: valid_in_0=1 with 8'h99, valid_in_1=0 -> out_0=10011001, out_1=10111100 (IDLE); with the macro, tx_count_0=1 and tx_count_1=0.
- Abort: enable=0 at bit 3 of a data byte -> out_x=0 next cycle, ready=0, active=0; enable=1 again -> 4 fresh BC bytes before data.
- Async reset mid-byte: reset pulse between edges -> outputs 0 immediately without waiting for a clock edge; after release with enable=1, full sync repeats.
- With macro: 65537 consecutive valid lane-0 slots -> tx_count_0 wraps to 1.

Source files
------------

// File: rtl/phy_tx_serializer_if.sv
// Upstream byte/valid handshake and serial-side outputs of phy_tx_serializer.
// Under PHY_TX_BYTE_COUNT_EN the bundle also carries the per-lane byte counters.
interface phy_tx_serializer_if;
  logic        enable;
  logic [7:0]  data_in_0;
  logic        valid_in_0;
  logic [7:0]  data_in_1;
  logic        valid_in_1;
  logic        ready;
  logic        out_0;
  logic        out_1;
  logic        active;
`ifdef PHY_TX_BYTE_COUNT_EN
  logic [15:0] tx_count_0;
  logic [15:0] tx_count_1;
`endif

  modport master (
    output enable, data_in_0, valid_in_0, data_in_1, valid_in_1,
    input  ready, out_0, out_1, active
`ifdef PHY_TX_BYTE_COUNT_EN
    , input tx_count_0, tx_count_1
`endif
  );

  modport slave (
    input  enable, data_in_0, valid_in_0, data_in_1, valid_in_1,
    output ready, out_0, out_1, active
`ifdef PHY_TX_BYTE_COUNT_EN
    , output tx_count_0, tx_count_1
`endif
  );
endinterface

// File: rtl/phy_tx_serializer.sv
// Two-lane byte-to-serial transmitter: comma sync burst after enable, then MSB-first data/idle bytes.
// Optional per-lane transmitted-byte counters are built when PHY_TX_BYTE_COUNT_EN is defined.
module phy_tx_serializer #(
  parameter int unsigned SYNC_BYTES = 4,
  parameter logic [7:0]  IDLE_BYTE  = 8'hBC
) (
  input logic                clk_8f,
  input logic                reset,
  phy_tx_serializer_if.slave tx
);

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_BYTES - 1);

  state_t     state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [3:0] sync_cnt, sync_cnt_nxt;
  logic [7:0] shreg_0, shreg_0_nxt;
  logic [7:0] shreg_1, shreg_1_nxt;
  logic       active_q;

  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      state    <= OFF;
      bit_cnt  <= '0;
      sync_cnt <= '0;
      shreg_0  <= '0;
      shreg_1  <= '0;
      active_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      sync_cnt <= sync_cnt_nxt;
      shreg_0  <= shreg_0_nxt;
      shreg_1  <= shreg_1_nxt;
      active_q <= (state_nxt == ACTIVE);
    end
  end

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    sync_cnt_nxt = sync_cnt;
    shreg_0_nxt  = shreg_0;
    shreg_1_nxt  = shreg_1;
    case (state)
      OFF: begin
        bit_cnt_nxt  = '0;
        sync_cnt_nxt = '0;
        shreg_0_nxt  = '0;
        shreg_1_nxt  = '0;
        if (tx.enable) begin
          state_nxt   = SYNC;
          shreg_0_nxt = IDLE_BYTE;
          shreg_1_nxt = IDLE_BYTE;
        end
      end
      SYNC, ACTIVE: begin
        if (!tx.enable) begin
          // Abort mid-byte: clearing the shift registers forces both lanes low next cycle.
          state_nxt    = OFF;
          bit_cnt_nxt  = '0;
          sync_cnt_nxt = '0;
          shreg_0_nxt  = '0;
          shreg_1_nxt  = '0;
        end else if (bit_cnt != 3'd7) begin
          shreg_0_nxt = {shreg_0[6:0], 1'b0};
          shreg_1_nxt = {shreg_1[6:0], 1'b0};
          bit_cnt_nxt = bit_cnt + 3'd1;
        end else begin
          bit_cnt_nxt = '0;
          if (state == SYNC && sync_cnt < SYNC_LAST) begin
            shreg_0_nxt  = IDLE_BYTE;
            shreg_1_nxt  = IDLE_BYTE;
            sync_cnt_nxt = sync_cnt + 4'd1;
          end else begin
            state_nxt   = ACTIVE;
            shreg_0_nxt = tx.valid_in_0 ? tx.data_in_0 : IDLE_BYTE;
            shreg_1_nxt = tx.valid_in_1 ? tx.data_in_1 : IDLE_BYTE;
          end
        end
      end
      default: state_nxt = OFF;
    endcase
  end

  assign tx.ready  = (bit_cnt == 3'd7) &&
                     (state == ACTIVE || (state == SYNC && sync_cnt == SYNC_LAST));
  assign tx.out_0  = shreg_0[7];
  assign tx.out_1  = shreg_1[7];
  assign tx.active = active_q;

`ifdef PHY_TX_BYTE_COUNT_EN
  logic [15:0] count_0, count_1;
  logic        slot_load;
  logic        count_clear;

  // A data slot is loaded exactly when ready is high and enable keeps the link running.
  assign slot_load   = tx.ready && tx.enable;
  assign count_clear = (state == OFF) && tx.enable;

  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      count_0 <= '0;
      count_1 <= '0;
    end else if (count_clear) begin
      count_0 <= '0;
      count_1 <= '0;
    end else if (slot_load) begin
      if (tx.valid_in_0) count_0 <= count_0 + 16'd1;
      if (tx.valid_in_1) count_1 <= count_1 + 16'd1;
    end
  end

  assign tx.tx_count_0 = count_0;
  assign tx.tx_count_1 = count_1;
`endif

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Self-checking bench for phy_tx_serializer: random byte traffic against a slot-position reference model.
`timescale 1ns/1ps
module tb_phy_tx_serializer;
  localparam int unsigned SB   = 4;
  localparam int          SBI  = SB;
  localparam logic [7:0]  IDLE = 8'hBC;

  typedef struct packed {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
  } slot_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  phy_tx_serializer_if tx();

  phy_tx_serializer #(.SYNC_BYTES(SB), .IDLE_BYTE(IDLE)) dut (
    .clk_8f(clk),
    .reset (reset),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  // Reference model: m_t counts cycles since enable was taken; the first SB*8 are comma bits.
  bit         m_on;
  int         m_t;
  logic [7:0] m_b0, m_b1;
  int         m_c0, m_c1;
  slot_t      dirq[$];

  function automatic logic exp_ready();
    return m_on && (m_t % 8 == 7) && (m_t >= 8*SBI - 1);
  endfunction

  function automatic logic exp_active();
    return m_on && (m_t >= 8*SBI);
  endfunction

  function automatic logic exp_out(input int lane);
    logic [7:0] b;
    int idx;
    if (!m_on) return 1'b0;
    if (m_t < 8*SBI) b = IDLE;
    else             b = (lane == 0) ? m_b0 : m_b1;
    idx = 7 - (m_t % 8);
    return b[idx];
  endfunction

  task automatic model_edge(input logic en, input logic v0, input logic [7:0] d0,
                            input logic v1, input logic [7:0] d1);
    if (!m_on) begin
      if (en) begin
        m_on = 1'b1; m_t = 0; m_c0 = 0; m_c1 = 0;
      end
    end else if (!en) begin
      m_on = 1'b0;
    end else begin
      if (exp_ready()) begin
        m_b0 = v0 ? d0 : IDLE;
        m_b1 = v1 ? d1 : IDLE;
        if (v0) m_c0 = (m_c0 + 1) % 65536;
        if (v1) m_c1 = (m_c1 + 1) % 65536;
      end
      m_t++;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("out_0",  {15'b0, tx.out_0},  {15'b0, exp_out(0)});
    chk("out_1",  {15'b0, tx.out_1},  {15'b0, exp_out(1)});
    chk("ready",  {15'b0, tx.ready},  {15'b0, exp_ready()});
    chk("active", {15'b0, tx.active}, {15'b0, exp_active()});
`ifdef PHY_TX_BYTE_COUNT_EN
    chk("tx_count_0", tx.tx_count_0, 16'(m_c0));
    chk("tx_count_1", tx.tx_count_1, 16'(m_c1));
`endif
  endtask

  // One cycle: check outputs at the falling edge, then drive the inputs for the next rising edge.
  task automatic step(input logic en);
    logic       v0, v1;
    logic [7:0] d0, d1;
    slot_t      s;
    @(negedge clk);
    check_all();
    v0 = ($urandom_range(0, 3) != 0);
    v1 = ($urandom_range(0, 3) != 0);
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    if (exp_ready() && en && dirq.size() > 0) begin
      s  = dirq.pop_front();
      v0 = s.v0; d0 = s.d0; v1 = s.v1; d1 = s.d1;
    end
    tx.enable     = en;
    tx.valid_in_0 = v0;
    tx.data_in_0  = d0;
    tx.valid_in_1 = v1;
    tx.data_in_1  = d1;
    model_edge(en, v0, d0, v1, d1);
  endtask

  initial begin
    bit found;
    reset         = 1'b1;
    tx.enable     = 1'b0;
    tx.valid_in_0 = 1'b0;
    tx.data_in_0  = '0;
    tx.valid_in_1 = 1'b0;
    tx.data_in_1  = '0;
    m_on = 1'b0; m_t = 0; m_b0 = '0; m_b1 = '0; m_c0 = 0; m_c1 = 0;

    // Reset values
    step(1'b0);
    step(1'b0);
    reset = 1'b0;
    step(1'b0);

    // Sync burst followed by directed data slots
    dirq.push_back('{1'b1, 8'hFF, 1'b1, 8'h00});
    dirq.push_back('{1'b1, 8'hEE, 1'b1, 8'hDD});
    dirq.push_back('{1'b1, 8'h99, 1'b0, 8'h5A});
    dirq.push_back('{1'b0, 8'h00, 1'b0, 8'hFF});
    repeat (80) step(1'b1);

    // Random traffic
    repeat (150) step(1'b1);

    // Abort at bit 3 of a data byte, then full re-sync
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (m_on && m_t >= 8*SBI && m_t % 8 == 3) found = 1'b1;
      else step(1'b1);
    end
    chk("abort_seek", {15'b0, found}, 16'd1);
    step(1'b0);
    step(1'b0);
    step(1'b0);
    repeat (70) step(1'b1);

    // Asynchronous reset in the middle of an all-ones byte
    dirq.delete();
    dirq.push_back('{1'b1, 8'hFF, 1'b1, 8'hFF});
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (m_on && m_t >= 8*SBI && m_t % 8 == 4 && m_b0 == 8'hFF && m_b1 == 8'hFF)
        found = 1'b1;
      else step(1'b1);
    end
    chk("areset_seek", {15'b0, found}, 16'd1);
    @(posedge clk);
    #1;
    chk("pre_areset_out_0",  {15'b0, tx.out_0},  16'd1);
    chk("pre_areset_active", {15'b0, tx.active}, 16'd1);
    #1 reset = 1'b1;
    #1;
    chk("areset_out_0",  {15'b0, tx.out_0},  16'd0);
    chk("areset_out_1",  {15'b0, tx.out_1},  16'd0);
    chk("areset_ready",  {15'b0, tx.ready},  16'd0);
    chk("areset_active", {15'b0, tx.active}, 16'd0);
    m_on = 1'b0; m_c0 = 0; m_c1 = 0;
    tx.enable = 1'b0;
    #1 reset = 1'b0;
    repeat (70) step(1'b1);

    // Long random run with occasional enable drops
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
